registro_id_ex: RTL and testbench
=================================

Name: registro_id_ex

Overview:
- Pipeline register between the decode (ID) and execute (EX) stages of the 5-stage MIPS datapath.
- Captures the register-file read data, the 32-bit sign-extended immediate produced by ExtensionSigno (valExtendido), the register specifiers, PC+4 and the WB/MEM/EX control bundles.
- Presents them to EX one cycle later, with stall (hold), flush (bubble insert) and a valid bit.

Parameters:
- DATA_W, 32, width of data, PC and immediate fields
- REG_W, 5, width of register specifier fields

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (from hazard/memory stall logic)
- flush  in  1  replace next contents with a bubble (branch taken / exception)
- id_valid  in  1  ID stage holds a real instruction
- id_pc4  in  DATA_W  PC+4 of the decoded instruction
- id_dato1  in  DATA_W  register-file read port 1 (rs)
- id_dato2  in  DATA_W  register-file read port 2 (rt)
- id_valExtendido  in  DATA_W  sign-extended immediate from ExtensionSigno
- id_rs, id_rt, id_rd  in  REG_W each  register specifiers
- id_ctrl_wb  in  2  {regWrite, memToReg}
- id_ctrl_mem  in  3  {memRead, memWrite, branch}
- id_ctrl_ex  in  4  {regDst, aluSrc, aluOp[1:0]}
- ex_valid, ex_pc4, ex_dato1, ex_dato2, ex_valExtendido, ex_rs, ex_rt, ex_rd, ex_ctrl_wb, ex_ctrl_mem, ex_ctrl_ex  out  same widths  registered copies
- stall_req  out  1  load-use stall request to PC/IF-ID (only driven by the optional feature; constant 0 otherwise)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); all state changes on the rising edge of clk.
- Reset: every output register is 0 (ex_valid=0, all ctrl=0, all data=0). stall_req=0.
- Per-edge priority: reset > flush > stall > load.
  - flush=1: load bubble, regardless of stall.
  - stall=1, flush=0: all outputs hold previous value.
  - Otherwise: load all id_* into ex_*, with latency exactly 1 cycle.
- Bubble: ex_valid=0, ex_ctrl_wb=0, ex_ctrl_mem=0, ex_ctrl_ex=0, and every data/specifier field 0. A bubble must never write a register or memory.
- Load with id_valid=0: treated as a bubble (ctrl and data forced to 0). EX never sees stale control.
- Immediate is stored bit-exact. No re-extension or truncation. 16'h8000 upstream arrives as 32'hFFFF8000.
- Stall held for N cycles: outputs unchanged for N cycles. Release: the next edge loads the current id_* values.
- Reset asserted mid-stall or mid-flush: reset wins on that edge. The next non-reset edge behaves normally.
- No combinational path from id_* to ex_*.

Optional Feature:
- Macro: ID_EX_LOAD_USE_DETECT_EN
- Defined:
  - Internal load-use detection. stall_req = ex_valid & ex_ctrl_mem[2] (memRead) & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt), gated by id_valid. stall_req is combinational from registered ex_* and live id_*.
  - While stall_req=1 and flush=0, the block loads a bubble on the next edge. Upstream holds IF/ID using stall_req.
  - The external stall input still has priority over the internal bubble insert.
- Undefined:
  - stall_req tied to 0; no comparator logic.
  - The external hazard unit drives stall/flush.

Decomposition:
- Shared package pipeline_pkg:
  - Control field widths (CTRL_WB_W=2, CTRL_MEM_W=3, CTRL_EX_W=4) and bit-index constants (MEMREAD_BIT etc.).
  - aluOp encodings (00 add, 01 sub, 10 R-type).
  - Bubble constant for the control bundles.
- One natural sub-module: detector_riesgo_carga (load-use comparator), instantiated only under ID_EX_LOAD_USE_DETECT_EN.

Test Plan:
- Reset: assert reset 2 cycles with random id_* -> all ex_* = 0, ex_valid=0, stall_req=0.
- Normal load: id_valid=1, id_valExtendido=32'hFFFF8000, id_dato1=32'h12345678, id_ctrl_ex=4'b0110 -> same values on ex_* after 1 edge; 32'h0000007F passes unchanged.
- Stall: load instr A, then stall=1 for 3 cycles while presenting B -> ex_* = A for 3 cycles, B appears on the edge after stall drops.
- Flush over stall: stall=1 and flush=1 on the same edge -> ex_valid=0, ex_ctrl_wb=0, ex_ctrl_mem=0; id_valid=0 load -> same bubble.
- Reset mid-stall: stall=1, reset=1 for one edge -> all zero; next edge with stall=0 loads id_*.
- Macro on: ex = lw with ex_rt=5, ex_valid=1; id_rs=5 -> stall_req=1, next ex_valid=0. With ex_rt=0, or memRead=0 -> stall_req=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline registers: control bundle widths,
// bit positions inside each bundle, aluOp encodings and bubble constants.
package pipeline_pkg;

    localparam int CTRL_WB_W  = 2;
    localparam int CTRL_MEM_W = 3;
    localparam int CTRL_EX_W  = 4;

    // ctrl_wb = {regWrite, memToReg}
    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;

    // ctrl_mem = {memRead, memWrite, branch}
    localparam int MEMREAD_BIT  = 2;
    localparam int MEMWRITE_BIT = 1;
    localparam int BRANCH_BIT   = 0;

    // ctrl_ex = {regDst, aluSrc, aluOp[1:0]}
    localparam int REGDST_BIT   = 3;
    localparam int ALUSRC_BIT   = 2;
    localparam int ALUOP_MSB    = 1;
    localparam int ALUOP_LSB    = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } aluop_e;

    localparam logic [CTRL_WB_W-1:0]  CTRL_WB_BUBBLE  = '0;
    localparam logic [CTRL_MEM_W-1:0] CTRL_MEM_BUBBLE = '0;
    localparam logic [CTRL_EX_W-1:0]  CTRL_EX_BUBBLE  = '0;

endpackage

// File: rtl/detector_riesgo_carga.sv
// Load-use hazard comparator: flags an ID instruction that reads the register
// a load currently in EX is about to write. Built only with ID_EX_LOAD_USE_DETECT_EN.
`ifdef ID_EX_LOAD_USE_DETECT_EN
module detector_riesgo_carga #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             stall_req
);

    logic rt_nonzero;
    logic rt_match;

    // $zero is never a real destination, so a load into it cannot cause a hazard
    assign rt_nonzero = (ex_rt != '0);
    assign rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign stall_req  = ex_valid && ex_mem_read && rt_nonzero && rt_match && id_valid;

endmodule
`endif

// File: rtl/registro_id_ex.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and valid bit.
// Optional internal load-use detection enabled by ID_EX_LOAD_USE_DETECT_EN.
module registro_id_ex
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_dato1,
    input  logic [DATA_W-1:0]     id_dato2,
    input  logic [DATA_W-1:0]     id_valExtendido,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic [REG_W-1:0]      id_rd,
    input  logic [CTRL_WB_W-1:0]  id_ctrl_wb,
    input  logic [CTRL_MEM_W-1:0] id_ctrl_mem,
    input  logic [CTRL_EX_W-1:0]  id_ctrl_ex,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic [DATA_W-1:0]     ex_dato1,
    output logic [DATA_W-1:0]     ex_dato2,
    output logic [DATA_W-1:0]     ex_valExtendido,
    output logic [REG_W-1:0]      ex_rs,
    output logic [REG_W-1:0]      ex_rt,
    output logic [REG_W-1:0]      ex_rd,
    output logic [CTRL_WB_W-1:0]  ex_ctrl_wb,
    output logic [CTRL_MEM_W-1:0] ex_ctrl_mem,
    output logic [CTRL_EX_W-1:0]  ex_ctrl_ex,
    output logic                  stall_req
);

    localparam int DATA_FIELDS_W = 4 * DATA_W + 3 * REG_W;
    localparam int STAGE_W = 1 + DATA_FIELDS_W + CTRL_WB_W + CTRL_MEM_W + CTRL_EX_W;

    logic [STAGE_W-1:0] id_stage;
    logic [STAGE_W-1:0] bubble_stage;
    logic [STAGE_W-1:0] stage_d;
    logic [STAGE_W-1:0] stage_q;
    logic               bubble_ins;

    assign id_stage = {id_valid, id_pc4, id_dato1, id_dato2, id_valExtendido,
                       id_rs, id_rt, id_rd, id_ctrl_wb, id_ctrl_mem, id_ctrl_ex};

    // Data fields are zeroed as well so EX never sees leftovers from an older instruction
    assign bubble_stage = {1'b0, {DATA_FIELDS_W{1'b0}},
                           CTRL_WB_BUBBLE, CTRL_MEM_BUBBLE, CTRL_EX_BUBBLE};

    assign {ex_valid, ex_pc4, ex_dato1, ex_dato2, ex_valExtendido,
            ex_rs, ex_rt, ex_rd, ex_ctrl_wb, ex_ctrl_mem, ex_ctrl_ex} = stage_q;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    detector_riesgo_carga #(
        .REG_W (REG_W)
    ) u_detector_riesgo_carga (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl_mem[MEMREAD_BIT]),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .stall_req   (stall_req)
    );
    assign bubble_ins = stall_req;
`else
    assign stall_req  = 1'b0;
    assign bubble_ins = 1'b0;
`endif

    // Priority below reset: flush > external stall > hazard bubble / invalid ID > load
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = bubble_stage;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (bubble_ins || !id_valid) begin
            stage_d = bubble_stage;
        end else begin
            stage_d = id_stage;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: tb/tb_registro_id_ex.sv
// Directed self-checking bench for registro_id_ex; the load-use section runs
// only when built with ID_EX_LOAD_USE_DETECT_EN.
module tb_registro_id_ex;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [31:0] id_pc4, id_dato1, id_dato2, id_valExtendido;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_ctrl_wb;
    logic [2:0]  id_ctrl_mem;
    logic [3:0]  id_ctrl_ex;
    logic        ex_valid;
    logic [31:0] ex_pc4, ex_dato1, ex_dato2, ex_valExtendido;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [1:0]  ex_ctrl_wb;
    logic [2:0]  ex_ctrl_mem;
    logic [3:0]  ex_ctrl_ex;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    registro_id_ex dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_pc4          (id_pc4),
        .id_dato1        (id_dato1),
        .id_dato2        (id_dato2),
        .id_valExtendido (id_valExtendido),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_ctrl_wb      (id_ctrl_wb),
        .id_ctrl_mem     (id_ctrl_mem),
        .id_ctrl_ex      (id_ctrl_ex),
        .ex_valid        (ex_valid),
        .ex_pc4          (ex_pc4),
        .ex_dato1        (ex_dato1),
        .ex_dato2        (ex_dato2),
        .ex_valExtendido (ex_valExtendido),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_ctrl_wb      (ex_ctrl_wb),
        .ex_ctrl_mem     (ex_ctrl_mem),
        .ex_ctrl_ex      (ex_ctrl_ex),
        .stall_req       (stall_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc4, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex);
        id_valid = v;  id_pc4 = pc4;  id_dato1 = d1;  id_dato2 = d2;
        id_valExtendido = imm;  id_rs = rs;  id_rt = rt;  id_rd = rd;
        id_ctrl_wb = wb;  id_ctrl_mem = mem;  id_ctrl_ex = ex;
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [31:0] pc4,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({tag, ".pc4"}, ex_pc4, pc4);
        chk({tag, ".dato1"}, ex_dato1, d1);
        chk({tag, ".dato2"}, ex_dato2, d2);
        chk({tag, ".imm"}, ex_valExtendido, imm);
        chk({tag, ".rs"}, {27'd0, ex_rs}, {27'd0, rs});
        chk({tag, ".rt"}, {27'd0, ex_rt}, {27'd0, rt});
        chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, rd});
        chk({tag, ".wb"}, {30'd0, ex_ctrl_wb}, {30'd0, wb});
        chk({tag, ".mem"}, {29'd0, ex_ctrl_mem}, {29'd0, mem});
        chk({tag, ".ex"}, {28'd0, ex_ctrl_ex}, {28'd0, ex});
    endtask

    task automatic chk_bubble(input string tag);
        chk_ex(tag, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'd0, 3'd0, 4'd0);
    endtask

    // Instruction A: R-type-ish add; instruction B: a different pattern in every field
    task automatic drive_a();
        set_id(1'b1, 32'h0000_0104, 32'h1234_5678, 32'hCAFE_BABE, 32'hFFFF_8000,
               5'd3, 5'd4, 5'd7, 2'b10, 3'b000, 4'b0110);
    endtask
    task automatic check_a(input string tag);
        chk_ex(tag, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'hCAFE_BABE, 32'hFFFF_8000,
               5'd3, 5'd4, 5'd7, 2'b10, 3'b000, 4'b0110);
    endtask
    task automatic drive_b();
        set_id(1'b1, 32'h0000_0208, 32'hA5A5_0F0F, 32'h0000_0011, 32'h0000_007F,
               5'd9, 5'd10, 5'd31, 2'b11, 3'b101, 4'b1001);
    endtask
    task automatic check_b(input string tag);
        chk_ex(tag, 1'b1, 32'h0000_0208, 32'hA5A5_0F0F, 32'h0000_0011, 32'h0000_007F,
               5'd9, 5'd10, 5'd31, 2'b11, 3'b101, 4'b1001);
    endtask

    initial begin
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        set_id(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
               5'($urandom), 2'b11, 3'b111, 4'b1111);
        tick();
        tick();
        chk_bubble("reset");
        chk("reset.stall_req", {31'd0, stall_req}, 32'd0);

        // Normal load, sign-extended immediate must pass bit-exact
        reset = 1'b0;
        drive_a();
        tick();
        check_a("load_a");
        id_valExtendido = 32'h0000_007F;
        tick();
        chk("load_imm7f", ex_valExtendido, 32'h0000_007F);

        // Stall for three edges while B is presented, then release
        drive_a();
        tick();
        drive_b();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_a($sformatf("stall_hold%0d", i));
        end
        stall = 1'b0;
        tick();
        check_b("stall_release");

        // Flush wins over stall
        stall = 1'b1;
        flush = 1'b1;
        drive_a();
        tick();
        chk_bubble("flush_over_stall");
        stall = 1'b0;
        flush = 1'b0;

        // Load with id_valid=0 is a bubble even though fields are non-zero
        drive_b();
        tick();
        check_b("reload_b");
        drive_a();
        id_valid = 1'b0;
        tick();
        chk_bubble("invalid_load");

        // Reset during stall clears, next edge loads normally
        drive_a();
        tick();
        check_a("pre_reset_a");
        stall = 1'b1;
        reset = 1'b1;
        drive_b();
        tick();
        chk_bubble("reset_mid_stall");
        stall = 1'b0;
        reset = 1'b0;
        tick();
        check_b("after_reset");

        // Load-use pattern: lw into r5 in EX, ID reads r5
        set_id(1'b1, 32'h0000_0300, 32'h0000_1000, 32'h0, 32'h0000_0004,
               5'd2, 5'd5, 5'd0, 2'b11, 3'b100, 4'b0100);
        tick();
        set_id(1'b1, 32'h0000_0304, 32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd8,
               2'b10, 3'b000, 4'b1010);
        #1;
`ifdef ID_EX_LOAD_USE_DETECT_EN
        chk("lu.stall_req", {31'd0, stall_req}, 32'd1);
        tick();
        chk_bubble("lu.bubble");
        chk("lu.after_bubble_req", {31'd0, stall_req}, 32'd0);
        tick();
        chk("lu.reload_pc4", ex_pc4, 32'h0000_0304);

        // lw into $zero: no hazard
        set_id(1'b1, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0,
               2'b11, 3'b100, 4'b0100);
        tick();
        id_rs = 5'd0;
        id_rt = 5'd0;
        #1;
        chk("lu.rt_zero", {31'd0, stall_req}, 32'd0);

        // sw-like (memRead=0) into r5: no hazard
        set_id(1'b1, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0,
               2'b00, 3'b010, 4'b0100);
        tick();
        id_rs = 5'd5;
        #1;
        chk("lu.no_memread", {31'd0, stall_req}, 32'd0);

        // Hazard present but external stall holds instead of inserting a bubble
        set_id(1'b1, 32'h0000_0600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0,
               2'b11, 3'b100, 4'b0100);
        tick();
        id_rt = 5'd5;
        id_rs = 5'd0;
        stall = 1'b1;
        #1;
        chk("lu.rt_match", {31'd0, stall_req}, 32'd1);
        tick();
        chk("lu.stall_priority_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu.stall_priority_pc4", ex_pc4, 32'h0000_0600);
        stall = 1'b0;
`else
        chk("lu.tied_off", {31'd0, stall_req}, 32'd0);
        tick();
        chk("lu.no_bubble_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu.no_bubble_pc4", ex_pc4, 32'h0000_0304);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
